qdec_ctx_mgr: RTL and testbench

Context-state manager between the CABAC syntax-element sub-FSMs and the binary arithmetic decoding engine. It accepts one bin request at a time (context address, run strobe, bypass flag), holds the 1024-entry context state store, and presents the addressed state to the engine. It writes the engine's updated state back to the store and returns the decoded bin to the requesting sub-FSM. Sub-FSM request outputs are OR-combined at the top level, since only one sub-FSM is active at a time.

---
 rtl/qdec_ctx_mgr.sv | 151 +++++++++++++++
 tb/tb_qdec_ctx_mgr.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qdec_ctx_mgr.sv
// CABAC context-state manager: 1024x7 context store, bin request FSM and engine handshake.
// Optional bin counters are enabled with QDEC_CTX_BINCNT_EN.
module qdec_ctx_mgr #(
    parameter int CTX_DEPTH = 1024,
    parameter int STATE_W   = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        ctx_addr,
    input  logic              ctx_addr_vld,
    input  logic              dec_run,
    input  logic              EPMode,
    output logic              dec_rdy,
    output logic              ruiBin,
    output logic              ruiBin_vld,
    input  logic              init_wr_en,
    input  logic [9:0]        init_wr_addr,
    input  logic [STATE_W-1:0] init_wr_data,
    output logic              init_err,
`ifdef QDEC_CTX_BINCNT_EN
    output logic [31:0]       bincnt_reg,
    output logic [31:0]       bincnt_ep,
`endif
    output logic              eng_req,
    output logic              eng_ep,
    output logic [5:0]        eng_pstate,
    output logic              eng_mps,
    input  logic              eng_rdy,
    input  logic              eng_bin,
    input  logic              eng_bin_vld,
    input  logic [5:0]        eng_new_pstate,
    input  logic              eng_new_mps
);

    typedef enum logic [2:0] {IDLE, RD, ISSUE, WAIT, WB} st_t;

    st_t                st, st_nxt;
    logic [9:0]         addr_q;
    logic [STATE_W-1:0] rd_data;
    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] new_q;
    logic               ep_q;
    logic               init_ok;
    logic               wr_en;
    logic [9:0]         wr_addr;
    logic [STATE_W-1:0] wr_data;
    logic               bin_evt;

    logic [STATE_W-1:0] mem [CTX_DEPTH];

    assign init_ok = init_wr_en && (st == IDLE);
    assign bin_evt = (st == WAIT) && eng_bin_vld;

    // Writes are gated by reset so an abandoned transaction never lands.
    assign wr_en   = rst_n && (init_ok || (st == WB));
    assign wr_addr = (st == WB) ? addr_q : init_wr_addr;
    assign wr_data = (st == WB) ? new_q : init_wr_data;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if ((st == IDLE) && ctx_addr_vld) begin
            if (init_ok && (init_wr_addr == ctx_addr))
                rd_data <= init_wr_data;
            else
                rd_data <= mem[ctx_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            st <= IDLE;
        else
            st <= st_nxt;
    end

    always_comb begin
        st_nxt  = st;
        dec_rdy = 1'b0;
        eng_req = 1'b0;
        case (st)
            IDLE: begin
                dec_rdy = 1'b1;
                if (ctx_addr_vld)
                    st_nxt = RD;
                else if (dec_run && EPMode)
                    st_nxt = ISSUE;
            end
            RD:    st_nxt = dec_run ? ISSUE : IDLE;
            ISSUE: begin
                eng_req = 1'b1;
                if (eng_rdy)
                    st_nxt = WAIT;
            end
            WAIT: begin
                if (eng_bin_vld)
                    st_nxt = ep_q ? IDLE : WB;
            end
            WB:      st_nxt = IDLE;
            default: st_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q     <= '0;
            state_q    <= '0;
            new_q      <= '0;
            ep_q       <= 1'b0;
            ruiBin     <= 1'b0;
            ruiBin_vld <= 1'b0;
            init_err   <= 1'b0;
        end else begin
            ruiBin_vld <= bin_evt;
            if (init_wr_en && (st != IDLE))
                init_err <= 1'b1;
            if ((st == IDLE) && ctx_addr_vld)
                addr_q <= ctx_addr;
            else if ((st == IDLE) && dec_run && EPMode)
                ep_q <= 1'b1;
            if (st == RD) begin
                state_q <= rd_data;
                if (dec_run)
                    ep_q <= EPMode;
            end
            if (bin_evt) begin
                ruiBin <= eng_bin;
                new_q  <= {eng_new_mps, eng_new_pstate};
            end
        end
    end

    assign eng_ep     = ep_q;
    assign eng_pstate = state_q[5:0];
    assign eng_mps    = state_q[6];

`ifdef QDEC_CTX_BINCNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bincnt_reg <= '0;
            bincnt_ep  <= '0;
        end else if (ruiBin_vld) begin
            if (ep_q)
                bincnt_ep <= bincnt_ep + 32'd1;
            else
                bincnt_reg <= bincnt_reg + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_qdec_ctx_mgr.sv
// Randomized bench for qdec_ctx_mgr against an array-based context store model.
// Covers init, regular/bypass bins, stalls, write-first, init_err and mid-op reset.
module tb_qdec_ctx_mgr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] ctx_addr;
    logic       ctx_addr_vld;
    logic       dec_run;
    logic       EPMode;
    logic       dec_rdy;
    logic       ruiBin;
    logic       ruiBin_vld;
    logic       init_wr_en;
    logic [9:0] init_wr_addr;
    logic [6:0] init_wr_data;
    logic       init_err;
    logic       eng_req;
    logic       eng_ep;
    logic [5:0] eng_pstate;
    logic       eng_mps;
    logic       eng_rdy;
    logic       eng_bin;
    logic       eng_bin_vld;
    logic [5:0] eng_new_pstate;
    logic       eng_new_mps;

    int checks = 0;
    int errors = 0;

    logic [6:0] mm [1024];
    bit         kn [1024];
    logic [9:0] known[$];

    qdec_ctx_mgr dut (
        .clk(clk), .rst_n(rst_n),
        .ctx_addr(ctx_addr), .ctx_addr_vld(ctx_addr_vld),
        .dec_run(dec_run), .EPMode(EPMode), .dec_rdy(dec_rdy),
        .ruiBin(ruiBin), .ruiBin_vld(ruiBin_vld),
        .init_wr_en(init_wr_en), .init_wr_addr(init_wr_addr),
        .init_wr_data(init_wr_data), .init_err(init_err),
        .eng_req(eng_req), .eng_ep(eng_ep), .eng_pstate(eng_pstate),
        .eng_mps(eng_mps), .eng_rdy(eng_rdy), .eng_bin(eng_bin),
        .eng_bin_vld(eng_bin_vld), .eng_new_pstate(eng_new_pstate),
        .eng_new_mps(eng_new_mps)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic init_wr(input logic [9:0] a, input logic [6:0] d);
        init_wr_en   = 1'b1;
        init_wr_addr = a;
        init_wr_data = d;
        tick;
        init_wr_en   = 1'b0;
        mm[a] = d;
        if (!kn[a]) begin
            kn[a] = 1'b1;
            known.push_back(a);
        end
    endtask

    task automatic do_reg(input logic [9:0] a, input logic b,
                          input logic [6:0] nw, input int lat,
                          input int stall, input bit fw,
                          input logic [6:0] fwd, input bit inj,
                          input logic [9:0] ia);
        logic [6:0] exp;
        chk("rdy_idle", 32'(dec_rdy), 32'd1);
        ctx_addr     = a;
        ctx_addr_vld = 1'b1;
        if (fw) begin
            init_wr_en   = 1'b1;
            init_wr_addr = a;
            init_wr_data = fwd;
            mm[a] = fwd;
        end
        exp = mm[a];
        tick;
        ctx_addr_vld = 1'b0;
        init_wr_en   = 1'b0;
        dec_run      = 1'b1;
        EPMode       = 1'b0;
        chk("rdy_rd", 32'(dec_rdy), 32'd0);
        chk("req_rd", 32'(eng_req), 32'd0);
        tick;
        dec_run = 1'b0;
        for (int i = 0; i <= stall; i++) begin
            eng_rdy = (i == stall);
            chk("req", 32'(eng_req), 32'd1);
            chk("ep", 32'(eng_ep), 32'd0);
            chk("pstate", 32'(eng_pstate), 32'(exp[5:0]));
            chk("mps", 32'(eng_mps), 32'(exp[6]));
            chk("rdy_busy", 32'(dec_rdy), 32'd0);
            tick;
        end
        eng_rdy = 1'b0;
        if (inj) begin
            init_wr_en   = 1'b1;
            init_wr_addr = ia;
            init_wr_data = ~mm[ia];
        end
        for (int i = 0; i < lat - 1; i++) begin
            chk("vld_wait", 32'(ruiBin_vld), 32'd0);
            tick;
            init_wr_en = 1'b0;
        end
        eng_bin_vld    = 1'b1;
        eng_bin        = b;
        eng_new_pstate = nw[5:0];
        eng_new_mps    = nw[6];
        tick;
        eng_bin_vld = 1'b0;
        init_wr_en  = 1'b0;
        chk("bin_vld", 32'(ruiBin_vld), 32'd1);
        chk("bin", 32'(ruiBin), 32'(b));
        chk("rdy_wb", 32'(dec_rdy), 32'd0);
        mm[a] = nw;
        tick;
        chk("rdy_done", 32'(dec_rdy), 32'd1);
        chk("vld_done", 32'(ruiBin_vld), 32'd0);
    endtask

    task automatic do_byp(input logic b, input int lat, input int stall);
        chk("byp_rdy_idle", 32'(dec_rdy), 32'd1);
        dec_run = 1'b1;
        EPMode  = 1'b1;
        tick;
        dec_run = 1'b0;
        EPMode  = 1'b0;
        for (int i = 0; i <= stall; i++) begin
            eng_rdy = (i == stall);
            chk("byp_req", 32'(eng_req), 32'd1);
            chk("byp_ep", 32'(eng_ep), 32'd1);
            chk("byp_rdy", 32'(dec_rdy), 32'd0);
            tick;
        end
        eng_rdy = 1'b0;
        for (int i = 0; i < lat - 1; i++) begin
            chk("byp_vld_wait", 32'(ruiBin_vld), 32'd0);
            tick;
        end
        eng_bin_vld    = 1'b1;
        eng_bin        = b;
        eng_new_pstate = 6'($urandom);
        eng_new_mps    = 1'($urandom);
        tick;
        eng_bin_vld = 1'b0;
        chk("byp_bin_vld", 32'(ruiBin_vld), 32'd1);
        chk("byp_bin", 32'(ruiBin), 32'(b));
        chk("byp_rdy_done", 32'(dec_rdy), 32'd1);
        tick;
        chk("byp_vld_done", 32'(ruiBin_vld), 32'd0);
    endtask

    task automatic chk_reset_vals;
        chk("rst_rdy", 32'(dec_rdy), 32'd1);
        chk("rst_bin", 32'(ruiBin), 32'd0);
        chk("rst_vld", 32'(ruiBin_vld), 32'd0);
        chk("rst_req", 32'(eng_req), 32'd0);
        chk("rst_ep", 32'(eng_ep), 32'd0);
        chk("rst_pstate", 32'(eng_pstate), 32'd0);
        chk("rst_mps", 32'(eng_mps), 32'd0);
        chk("rst_err", 32'(init_err), 32'd0);
    endtask

    initial begin
        logic [9:0] a;
        logic [9:0] a2;
        logic [6:0] sv;
        int         op;

        rst_n = 1'b0;
        ctx_addr = '0; ctx_addr_vld = 0; dec_run = 0; EPMode = 0;
        init_wr_en = 0; init_wr_addr = '0; init_wr_data = '0;
        eng_rdy = 0; eng_bin = 0; eng_bin_vld = 0;
        eng_new_pstate = '0; eng_new_mps = 0;
        for (int i = 0; i < 1024; i++) kn[i] = 1'b0;
        tick; tick;
        rst_n = 1'b1;
        tick;
        chk_reset_vals();

        init_wr(10'h02A, 7'h45);
        while (known.size() < 8) begin
            a = 10'($urandom);
            if (!kn[a]) init_wr(a, 7'($urandom));
        end

        do_reg(10'h02A, 1'b1, 7'h07, 2, 0, 0, '0, 0, '0);
        chk("dir_model", 32'(mm[10'h02A]), 32'h07);
        do_reg(10'h02A, 1'b0, 7'($urandom), 1, 0, 0, '0, 0, '0);

        sv = mm[10'h02A];
        do_byp(1'b1, 3, 1);
        do_reg(10'h02A, 1'b1, sv, 1, 0, 0, '0, 0, '0);

        do_reg(known[2], 1'b0, 7'($urandom), 2, 5, 0, '0, 0, '0);
        do_reg(known[3], 1'b1, 7'($urandom), 1, 0, 1, 7'($urandom), 0, '0);

        for (int n = 0; n < 40; n++) begin
            op = int'($urandom_range(0, 9));
            a  = known[$urandom_range(0, known.size() - 1)];
            if (op < 2)
                init_wr(a, 7'($urandom));
            else if (op < 8)
                do_reg(a, 1'($urandom), 7'($urandom),
                       int'($urandom_range(1, 4)), int'($urandom_range(0, 3)),
                       ($urandom_range(0, 4) == 0), 7'($urandom), 0, '0);
            else
                do_byp(1'($urandom), int'($urandom_range(1, 4)),
                       int'($urandom_range(0, 3)));
        end

        a2 = known[1];
        do_reg(10'h02A, 1'b0, 7'($urandom), 2, 0, 0, '0, 1, a2);
        chk("err_set", 32'(init_err), 32'd1);
        do_reg(a2, 1'b1, 7'($urandom), 1, 0, 0, '0, 0, '0);
        chk("err_sticky", 32'(init_err), 32'd1);

        a  = 10'h02A;
        sv = mm[a];
        ctx_addr = a; ctx_addr_vld = 1'b1;
        tick;
        ctx_addr_vld = 1'b0; dec_run = 1'b1;
        tick;
        dec_run = 1'b0; eng_rdy = 1'b1;
        tick;
        eng_rdy = 1'b0;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        eng_bin_vld = 1'b1; eng_bin = 1'b1;
        eng_new_pstate = ~sv[5:0]; eng_new_mps = ~sv[6];
        tick;
        eng_bin_vld = 1'b0;
        chk_reset_vals();
        tick;
        chk("late_vld", 32'(ruiBin_vld), 32'd0);
        do_reg(a, 1'b0, 7'($urandom), 1, 0, 0, '0, 0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
